// File: rtl/l2_response_queue.sv
// l2_response_queue
//   Circular-buffer FIFO between the L2 update stage and the per-core response
//   distribution. The update stage cannot stall, so rspq_almost_full is raised
//   SLACK entries before full. That gives the L2 arbiter time to stop issuing
//   requests while the requests already in the pipeline drain into the queue.
//
// Handshake (valid/ready):
//   An entry transfers on a clock edge where rspq_response_valid and
//   rspq_response_ready are both high. While rspq_response_valid is high, the
//   head entry stays stable and valid stays high until that transfer happens.
//   Ready while the queue is empty is ignored.
//   All outputs are decoded from registers only. No input reaches an output
//   in the same cycle.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   l2_response_valid/     push side from the update stage (no backpressure)
//   l2_response
//   rspq_almost_full       tells the arbiter to stop issuing (count >= DEPTH-SLACK)
//   rspq_response_valid/   head of the queue towards the cores
//   rspq_response/
//   rspq_response_ready
//   rspq_count             current occupancy, 0..DEPTH
//   rspq_overflow          sticky flag: a response was dropped on a full queue
//
// Parameters:
//   DEPTH       number of entries (power of two, >= 2)
//   SLACK       requests that may still be in flight when almost-full asserts
//   DROP_CHECK  enables the simulation-only drop assertion

package l2_response_queue_pkg;

  typedef enum logic [1:0] {
    L2RSP_LOAD_ACK  = 2'd0,
    L2RSP_STORE_ACK = 2'd1,
    L2RSP_FLUSH_ACK = 2'd2,
    L2RSP_INVAL_ACK = 2'd3
  } l2rsp_type_t;

  typedef struct packed {
    logic        status;
    logic [1:0]  core;
    logic [7:0]  id;
    l2rsp_type_t packet_type;
    logic [1:0]  cache_type;
    logic [31:0] data;
    logic [31:0] address;
  } l2rsp_packet_t;

endpackage

module l2_response_queue
  import l2_response_queue_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int SLACK      = 4,
  parameter bit DROP_CHECK = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       l2_response_valid,
  input  l2rsp_packet_t              l2_response,
  output logic                       rspq_almost_full,
  output logic                       rspq_response_valid,
  output l2rsp_packet_t              rspq_response,
  input  logic                       rspq_response_ready,
  output logic [$clog2(DEPTH):0]     rspq_count,
  output logic                       rspq_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_COUNT   = CW'(DEPTH - SLACK);

  l2rsp_packet_t r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_COUNT);

  // A pop is only possible on a non-empty queue. Because of that, "empty + push
  // + ready" becomes a plain push. A push into a full queue is allowed only
  // when the head leaves in the same cycle.
  assign w_pop  = !w_empty && rspq_response_ready;
  assign w_push = l2_response_valid && (!w_full || w_pop);
  assign w_drop = l2_response_valid && w_full && !w_pop;

  // Pointers wrap by natural overflow because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Storage is not reset. Entries are only visible through r_count, and
  // r_count is reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= l2_response;
  end

  always_ff @(posedge clk) begin
    if (DROP_CHECK && !reset) begin
      assert (!w_drop)
        else $error("l2_response_queue: response id %0d dropped, queue full",
                    l2_response.id);
    end
  end

  assign rspq_response_valid = !w_empty;
  assign rspq_response       = r_mem[r_rd_ptr];
  assign rspq_almost_full    = (r_count >= AF_COUNT);
  assign rspq_count          = r_count;
  assign rspq_overflow       = r_overflow;

endmodule

// File: tb/tb_l2_response_queue.sv
// Testbench for l2_response_queue.
//   Runs directed steps from the block's test plan, then a randomized phase.
//   All expectations come from a packet-level queue model.
module tb_l2_response_queue;
  import l2_response_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int SLACK = 4;
  localparam int PW    = $bits(l2rsp_packet_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                   l2_response_valid;
  l2rsp_packet_t          l2_response;
  logic                   rspq_almost_full;
  logic                   rspq_response_valid;
  l2rsp_packet_t          rspq_response;
  logic                   rspq_response_ready;
  logic [$clog2(DEPTH):0] rspq_count;
  logic                   rspq_overflow;

  l2_response_queue #(
    .DEPTH(DEPTH), .SLACK(SLACK), .DROP_CHECK(1'b0)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .l2_response_valid   (l2_response_valid),
    .l2_response         (l2_response),
    .rspq_almost_full    (rspq_almost_full),
    .rspq_response_valid (rspq_response_valid),
    .rspq_response       (rspq_response),
    .rspq_response_ready (rspq_response_ready),
    .rspq_count          (rspq_count),
    .rspq_overflow       (rspq_overflow)
  );

  // ---------------- scoreboard / model ----------------
  logic [PW-1:0] exp_q[$];
  logic          m_ovf;
  int            n_tests;
  int            n_fail;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  function automatic l2rsp_packet_t mk_pkt(input logic [7:0] id);
    l2rsp_packet_t p;
    p.status      = 1'($urandom_range(0, 1));
    p.core        = 2'($urandom_range(0, 3));
    p.id          = id;
    p.packet_type = l2rsp_type_t'(2'($urandom_range(0, 3)));
    p.cache_type  = 2'($urandom_range(0, 3));
    p.data        = $urandom;
    p.address     = $urandom;
    return p;
  endfunction

  task automatic check_state(input string tag);
    int sz;
    sz = exp_q.size();
    chk({tag, "_valid"}, rspq_response_valid, (sz != 0));
    chk({tag, "_count"}, rspq_count, sz);
    chk({tag, "_afull"}, rspq_almost_full, (sz >= DEPTH - SLACK));
    chk({tag, "_ovf"},   rspq_overflow, m_ovf);
    if (sz != 0) chk({tag, "_head"}, rspq_response, exp_q[0]);
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1. Drives one cycle, predicts it, then checks at posedge+1.
  task automatic cycle(input string tag, input logic v, input l2rsp_packet_t p,
                       input logic rdy);
    bit do_pop, do_push;
    l2_response_valid   = v;
    l2_response         = p;
    rspq_response_ready = rdy;
    @(negedge clk);
    do_pop  = rdy && (exp_q.size() != 0);
    if (do_pop) chk({tag, "_popdata"}, rspq_response, exp_q[0]);
    do_push = v && ((exp_q.size() < DEPTH) || do_pop);
    @(posedge clk);
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(p);
    else if (v) m_ovf = 1'b1;
    #1;
    check_state(tag);
  endtask

  task automatic idle_pop(input string tag);
    cycle(tag, 1'b0, '0, 1'b1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (exp_q.size() != 0) idle_pop(tag);
    end
    chk({tag, "_drained"}, rspq_count, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    l2rsp_packet_t p;
    n_tests = 0;
    n_fail  = 0;
    m_ovf   = 1'b0;
    reset   = 1'b1;
    l2_response_valid   = 1'b0;
    l2_response         = '0;
    rspq_response_ready = 1'b0;
    #1;
    check_state("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single packet: id=3, core=1, LOAD_ACK.
    p = mk_pkt(8'd3);
    p.core = 2'd1;
    p.packet_type = L2RSP_LOAD_ACK;
    cycle("single_push", 1'b1, p, 1'b0);
    chk("single_id",   rspq_response.id, 3);
    chk("single_core", rspq_response.core, 1);
    chk("single_type", rspq_response.packet_type, L2RSP_LOAD_ACK);
    idle_pop("single_pop");
    chk("single_empty", rspq_response_valid, 0);

    // Almost-full threshold.
    for (int i = 0; i < 4; i++) begin
      cycle("af_fill", 1'b1, mk_pkt(8'(i)), 1'b0);
      chk("af_level", rspq_almost_full, (i == 3));
    end
    idle_pop("af_pop1");
    chk("af_clear", rspq_almost_full, 0);
    drain("af_drain");

    // Full with push and pop in the same cycle.
    for (int i = 0; i < DEPTH; i++) cycle("full_fill", 1'b1, mk_pkt(8'(i)), 1'b0);
    chk("full_count", rspq_count, DEPTH);
    cycle("full_pushpop", 1'b1, mk_pkt(8'd8), 1'b1);
    chk("full_pp_count", rspq_count, DEPTH);
    chk("full_pp_ovf", rspq_overflow, 0);
    for (int i = 1; i <= 8; i++) begin
      chk("full_order", rspq_response.id, i);
      idle_pop("full_drain");
    end
    chk("full_empty", rspq_count, 0);

    // Drop on full with ready low.
    for (int i = 0; i < DEPTH; i++) cycle("drop_fill", 1'b1, mk_pkt(8'(i)), 1'b0);
    cycle("drop_push", 1'b1, mk_pkt(8'd99), 1'b0);
    chk("drop_ovf", rspq_overflow, 1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drop_order", rspq_response.id, i);
      idle_pop("drop_drain");
    end
    chk("drop_empty", rspq_response_valid, 0);
    chk("drop_ovf_sticky", rspq_overflow, 1);

    // Continuous push and pop; the empty+push+ready cycle is a plain push.
    for (int i = 0; i < 20; i++) begin
      cycle("stream", 1'b1, mk_pkt(8'(i)), 1'b1);
      chk("stream_count", rspq_count, 1);
    end
    drain("stream_drain");

    // Asynchronous reset with 5 entries queued.
    for (int i = 0; i < 5; i++) cycle("rst_fill", 1'b1, mk_pkt(8'(40 + i)), 1'b0);
    l2_response_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    m_ovf = 1'b0;
    chk("async_valid", rspq_response_valid, 0);
    chk("async_count", rspq_count, 0);
    chk("async_afull", rspq_almost_full, 0);
    chk("async_ovf", rspq_overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cycle("post_rst_push", 1'b1, mk_pkt(8'd9), 1'b0);
    chk("post_rst_id", rspq_response.id, 9);
    idle_pop("post_rst_pop");

    // Randomized phase. Push/pop rates change per block so the queue reaches
    // both full and empty.
    for (int blk = 0; blk < 8; blk++) begin
      int pv, pr;
      pv = $urandom_range(20, 90);
      pr = $urandom_range(20, 90);
      for (int i = 0; i < 50; i++) begin
        cycle("rand",
              ($urandom_range(0, 99) < pv),
              mk_pkt(8'($urandom)),
              ($urandom_range(0, 99) < pr));
      end
    end
    drain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_response_queue.md
# l2_response_queue

Buffers L2 response packets produced by the L2 pipeline update stage and delivers them to the core interconnect with a valid/ready handshake. The update stage cannot stall, so this block raises an almost-full signal early enough for the L2 request arbiter to stop issuing new requests while responses already in flight drain into the queue. The block sits directly downstream of the update stage, between the L2 pipeline and the response distribution to cores.

## Interface
- DEPTH, 8, number of response entries; must be a power of two and at least 2.
- SLACK, 4, number of requests that can already be in the L2 pipeline when almost-full asserts; must be less than DEPTH.

- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- l2_response_valid  input  1  response packet from the update stage is valid this cycle.
- l2_response  input  l2rsp_packet_t  response packet from the update stage.
- rspq_almost_full  output  1  to the L2 arbiter: stop accepting new requests.
- rspq_response_valid  output  1  head entry is valid.
- rspq_response  output  l2rsp_packet_t  head entry.
- rspq_response_ready  input  1  consumer accepts the head entry this cycle.
- rspq_count  output  $clog2(DEPTH)+1  current occupancy.
- rspq_overflow  output  1  sticky error flag: a response was dropped.

## Operation
- Storage is a circular buffer of DEPTH entries with a write pointer and a read pointer, each $clog2(DEPTH) bits wide. Pointers wrap modulo DEPTH through natural overflow.
- Occupancy is held in a count register of $clog2(DEPTH)+1 bits.
- Push:
  - Occurs when l2_response_valid is high and the queue is either not full, or full with a pop in the same cycle.
  - The entry is written at the write pointer, and the write pointer increments.
- Pop:
  - Occurs when rspq_response_valid and rspq_response_ready are both high.
  - The read pointer increments.
  - rspq_response_ready while the queue is empty is ignored.
- Count update:
  - Push only: count + 1.
  - Pop only: count − 1.
  - Push and pop together, or neither: count unchanged.
- Drop:
  - Occurs when l2_response_valid is high, count == DEPTH, and there is no pop that cycle.
  - The packet is discarded and rspq_overflow sets.
  - rspq_overflow stays set until reset.
  - A simulation assertion fires on a drop.
- Output decoding:
  - rspq_response_valid = (count != 0).
  - rspq_response = storage[read pointer].
  - rspq_almost_full = (count >= DEPTH − SLACK).
  - All three are decoded from registers only, with no combinational path from l2_response_valid or rspq_response_ready.
- The packet is passed through unmodified: all fields (status, core, id, packet_type, cache_type, data, address) leave exactly as they arrived.
- Ordering is strict FIFO.

## Timing
- Reset values: count 0, both pointers 0, rspq_response_valid 0, rspq_almost_full 0, rspq_overflow 0, rspq_count 0. Storage contents are not reset.
- Reset is asynchronous: asserting it mid-operation immediately empties the queue and discards any entries.
- Latency:
  - A packet pushed in cycle N into an empty queue appears on rspq_response with rspq_response_valid high in cycle N+1.
  - There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained.
- Almost-full timing:
  - rspq_almost_full changes in the cycle after the count crosses the threshold.
  - The arbiter stops issuing the cycle it sees rspq_almost_full high.
  - SLACK covers the arbiter-to-update-stage depth plus 1.
- Handshake:
  - Once rspq_response_valid is high, the head entry holds stable until it is popped.
  - rspq_response_valid never drops without a pop.
- Boundary cases:
  - Empty with a simultaneous push and ready: the push is accepted, no pop occurs, and count becomes 1.
  - Full with a simultaneous push and pop: both occur, and count stays at DEPTH.

## Test plan
- Reset, then push one packet (id=3, core=1, type L2RSP_LOAD_ACK) with ready held low -> rspq_response_valid rises one cycle later, all fields match, rspq_count=1; assert ready -> valid falls the next cycle and rspq_count=0.
- With DEPTH=8 and SLACK=4, push 4 packets with ready low -> rspq_almost_full is low after 3 pushes and high the cycle after the 4th; pop 1 -> almost_full deasserts the next cycle.
- Fill to 8, then push and pop in the same cycle -> count stays 8, rspq_overflow stays 0, and the output order equals the push order (ids 0..8).
- Fill to 8, then push with ready low -> the packet is dropped, rspq_overflow=1 and stays 1, and a drain yields exactly ids 0..7.
- Continuous push and pop for 20 cycles with ids 0..19 -> ids come out in order, the pointers wrap twice, and count stays constant.
- Assert reset with 5 entries queued -> in the same cycle valid=0, count=0 and almost_full=0; after reset, a new push of id=9 is the first packet out.
